// File: rtl/axil_eq_pkg.sv
// Shared types and constants for the AXI4-Lite register block.
package axil_eq_pkg;

  typedef logic [0:0] w_state_t;
  localparam w_state_t W_IDLE = 1'b0;
  localparam w_state_t W_RESP = 1'b1;

  typedef logic [0:0] r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned ID_REG_IDX  = 15;
  localparam int unsigned NUM_RW_REGS = NUM_REGS - 1;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: each lane takes the new byte where its strobe is set, else keeps the old one.
module axil_strb_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi4lite_eq_regs.sv
// AXI4-Lite slave with 15 RW registers plus a read-only ID word at index 15.
// Define AXIL_EQ_SLVERR_EN to answer writes to the ID register with SLVERR.
module axi4lite_eq_regs
  import axil_eq_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE           = 32'hE0A1_0001
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_RW_REGS*32-1:0]       reg_out,
  output logic [NUM_RW_REGS-1:0]          reg_wr_pulse
);

  w_state_t         w_state_q;
  r_state_t         r_state_q;
  logic [1:0]       bresp_q;
  logic [31:0]      rdata_q;
  logic [31:0]      regs_q [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] pulse_q;

  logic [3:0]  w_idx, r_idx;
  logic        w_accept, r_accept, w_to_id;
  logic [31:0] old_word, merged, read_word;
  logic        unused_addr_lsbs;

  assign w_idx   = S_AXI_AWADDR[5:2];
  assign r_idx   = S_AXI_ARADDR[5:2];
  assign w_to_id = (w_idx == 4'(ID_REG_IDX));
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Handshakes are combinational so a write completes in the same cycle both valids appear.
  assign w_accept = S_AXI_ARESETN && (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign r_accept = S_AXI_ARESETN && (r_state_q == R_IDLE) && S_AXI_ARVALID;

  assign S_AXI_AWREADY = w_accept;
  assign S_AXI_WREADY  = w_accept;
  assign S_AXI_ARREADY = r_accept;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign reg_wr_pulse  = pulse_q;

  always_comb begin
    old_word  = '0;
    read_word = ID_VALUE;
    for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
      if (w_idx == 4'(i)) old_word = regs_q[i];
      if (r_idx == 4'(i)) read_word = regs_q[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
      reg_out[32*i +: 32] = regs_q[i];
    end
  end

  axil_strb_merge u_merge (
    .old_word (old_word),
    .new_word (S_AXI_WDATA),
    .strb     (S_AXI_WSTRB),
    .merged   (merged)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int unsigned i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= '0;
    end else begin
      pulse_q <= '0;
      unique case (w_state_q)
        W_IDLE: begin
          if (w_accept) begin
            w_state_q <= W_RESP;
`ifdef AXIL_EQ_SLVERR_EN
            bresp_q   <= w_to_id ? RESP_SLVERR : RESP_OKAY;
`else
            bresp_q   <= RESP_OKAY;
`endif
            // Index 15 never matches, so ID writes leave all state untouched.
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
              if (w_idx == 4'(i)) begin
                regs_q[i]  <= merged;
                pulse_q[i] <= 1'b1;
              end
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (r_accept) begin
            r_state_q <= R_DATA;
            rdata_q   <= read_word;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4lite_eq_regs.md
AXI4LITE_EQ_REGS -- requirements
Module: axi4lite_eq_regs

Interface
REQ-001 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width; 16 word registers.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 Parameter ID_VALUE, default 32'hE0A1_0001, constant returned by register 15.
REQ-004 S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 S_AXI_AWADDR in 6, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-007 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-009 S_AXI_ARADDR in 6, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-010 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-011 reg_out  out  15*32  flat bus; word i (bits 32i+31:32i) equals register i, i=0..14.
REQ-012 reg_wr_pulse  out  15  one-cycle strobe, bit i high the cycle after register i is written.

Function
REQ-013 Register index SHALL be addr[5:2]; addr[1:0] ignored.
REQ-014 Write FSM states W_IDLE, W_RESP; in W_IDLE, when AWVALID and WVALID are both high, AWREADY and WREADY SHALL assert together for exactly one cycle and the FSM SHALL go to W_RESP.
REQ-015 AWVALID without WVALID, or WVALID without AWVALID, SHALL NOT be accepted; READY stays low until both are present.
REQ-016 Write update SHALL apply per byte lane where WSTRB bit set; WSTRB=0 leaves register unchanged but still completes with a response.
REQ-017 In W_RESP, BVALID SHALL be high with BRESP stable until BREADY; on BVALID&BREADY, return to W_IDLE; no new write accepted while BVALID is high.
REQ-018 Read FSM states R_IDLE, R_DATA; in R_IDLE, ARVALID SHALL cause ARREADY high for one cycle, RDATA latched, move to R_DATA.
REQ-019 In R_DATA, RVALID SHALL be high, RDATA/RRESP held until RREADY; RRESP always 2'b00.
REQ-020 Register 15 SHALL read ID_VALUE; registers 0..14 read their stored value.
REQ-021 Read and write FSMs SHALL be independent; a same-cycle read and write to one register SHALL return the pre-write value.
REQ-022 Back-to-back: with BREADY/RREADY held high, one transaction per channel every 2 cycles.

Reset
REQ-023 On S_AXI_ARESETN low at a clock edge: registers 0..14 = 0, both FSMs idle, all READY/VALID outputs 0, BRESP=RRESP=0, RDATA=0, reg_wr_pulse=0.
REQ-024 Reset mid-transaction SHALL abandon it; no response is issued afterwards.

Configuration
REQ-025 Macro AXIL_EQ_SLVERR_EN defined: write to register 15 SHALL return BRESP=2'b10 (SLVERR), no state change, no pulse.
REQ-026 Macro undefined: write to register 15 SHALL return BRESP=2'b00 and be silently ignored.

Structure
REQ-027 Package axil_eq_pkg SHALL hold FSM state typedefs, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, NUM_REGS=16, ID_REG_IDX=15.
REQ-028 Write byte-merge logic SHALL be one sub-module, axil_strb_merge (old word, new word, strobe -> merged word).

Verification
REQ-029 Reset, then read addr 0x3C -> RDATA=32'hE0A1_0001, RRESP=0, RVALID one cycle after ARREADY.
REQ-030 Write 0x04 data 32'h1234_5678 WSTRB 4'hF, BREADY=1 -> BVALID next cycle, BRESP=0, reg_wr_pulse[1] for one cycle, reg_out word1=32'h1234_5678.
REQ-031 Then write 0x04 data 32'hAABB_CCDD WSTRB 4'b0101 -> word1=32'h12BB_56DD.
REQ-032 AWVALID at cycle 0, WVALID at cycle 3 -> AWREADY/WREADY first high cycle 3; BVALID held 5 cycles with BREADY low, BRESP stable.
REQ-033 Write 0x3C -> BRESP=2'b10 with AXIL_EQ_SLVERR_EN, 2'b00 without; readback still ID_VALUE.
REQ-034 Assert reset while BVALID=1 -> BVALID=0 next cycle, registers 0..14 zero.
